// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  // Port ownership state.
  typedef enum logic [0:0] {
    FREE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Wrap-aware age compare: a is older than b when (a - b) mod 2**width has
  // its top bit set. The low `width` bits of a 32-bit difference are the
  // same as the modular difference, so only bit width-1 needs inspecting.
  function automatic logic issue_id_older(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [31:0] diff;
    logic [31:0] shifted;
    diff    = a - b;
    shifted = diff >> (width - 32'd1);
    return shifted[0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational oldest-first picker: among valid requesters, select the one
// with the oldest issue_id; equal ids resolve to the lowest index.
module oldest_first_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int ID_WIDTH = 4,
  parameter int IDX_W    = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1
) (
  input  logic [NUM_SIC-1:0]          valid,
  input  logic [NUM_SIC*ID_WIDTH-1:0] ids,
  output logic [NUM_SIC-1:0]          onehot,
  output logic [IDX_W-1:0]            idx,
  output logic                        any
);

  logic                found_s;
  logic [ID_WIDTH-1:0] best_id_s;
  logic [IDX_W-1:0]    best_idx_s;
  logic [ID_WIDTH-1:0] cand_id_s;

  // Linear scan; a later index only replaces the best if strictly older,
  // which gives the lower index the win on equal ids.
  always_comb begin
    found_s    = 1'b0;
    best_id_s  = '0;
    best_idx_s = '0;
    cand_id_s  = '0;
    for (int i = 0; i < NUM_SIC; i++) begin
      cand_id_s = ids[i*ID_WIDTH +: ID_WIDTH];
      if (valid[i] && (!found_s ||
          issue_id_older(32'(cand_id_s), 32'(best_id_s), ID_WIDTH))) begin
        found_s    = 1'b1;
        best_id_s  = cand_id_s;
        best_idx_s = IDX_W'(i);
      end else begin
        found_s    = found_s;
      end
    end
  end

  // One-hot form of the selected index, zero when nobody is valid.
  always_comb begin
    onehot = '0;
    if (found_s) begin
      onehot[best_idx_s] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

  assign idx = best_idx_s;
  assign any = found_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: grants the single memory port to the oldest
// requesting SIC, holds it until that owner pulses release, and muxes the
// owner's address/data/commit onto the memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SIC-1:0]          req_read,
  input  logic [NUM_SIC-1:0]          req_write,
  input  logic [NUM_SIC*ID_WIDTH-1:0] req_issue_id,
  input  logic [NUM_SIC*32-1:0]       req_addr,
  input  logic [NUM_SIC*32-1:0]       req_wdata,
  input  logic [NUM_SIC-1:0]          req_commit,
  input  logic [NUM_SIC-1:0]          req_release,
  output logic [NUM_SIC-1:0]          grant,
  output logic [31:0]                 rdata_bcast,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic                        mem_we,
  input  logic [31:0]                 mem_rdata,
  output logic                        busy,
  output logic                        err_bad_release
);

  localparam int IDX_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_SIC-1:0] grant_q, grant_d;
  logic               err_q, err_d;

  logic [NUM_SIC-1:0] active_s;
  logic [NUM_SIC-1:0] pick_onehot_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               bad_release_s;

  assign active_s = req_read | req_write;

  oldest_first_picker #(
    .NUM_SIC  (NUM_SIC),
    .ID_WIDTH (ID_WIDTH),
    .IDX_W    (IDX_W)
  ) u_picker (
    .valid  (active_s),
    .ids    (req_issue_id),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Ownership FSM next state plus bad-release detection.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    bad_release_s = 1'b0;
    case (state_q)
      FREE: begin
        // Any release while nobody owns the port is a protocol error.
        bad_release_s = |req_release;
        if (pick_any_s) begin
          state_d = OWNED;
          owner_d = pick_idx_s;
          grant_d = pick_onehot_s;
        end else begin
          grant_d = '0;
        end
      end
      OWNED: begin
        bad_release_s = |(req_release & ~grant_q);
        if (req_release[owner_q]) begin
          state_d = FREE;
          grant_d = '0;
        end else begin
          grant_d = grant_q;
        end
      end
      default: begin
        state_d = FREE;
        owner_d = '0;
        grant_d = '0;
      end
    endcase
    err_d = err_q | bad_release_s;
  end

  // State, owner, grant and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      owner_q <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // AND-OR mux of the owner's data path; grant_q is zero unless OWNED, so
  // non-owners can never reach the memory.
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_we    = 1'b0;
    for (int i = 0; i < NUM_SIC; i++) begin
      mem_addr  = mem_addr  | (req_addr[i*32 +: 32]  & {32{grant_q[i]}});
      mem_wdata = mem_wdata | (req_wdata[i*32 +: 32] & {32{grant_q[i]}});
      mem_we    = mem_we | (grant_q[i] & req_write[i] & req_commit[i]);
    end
  end

  assign grant           = grant_q;
  assign busy            = (state_q == OWNED);
  assign err_bad_release = err_q;
  assign rdata_bcast     = mem_rdata;

endmodule
